// File: rtl/multiply_complex_sched_pkg.sv
// Shared definitions for the complex-multiplier scheduler and its arbiter.
package multiply_complex_sched_pkg;

   localparam int unsigned MCS_WIDTH_DEF        = 32;
   localparam int unsigned MCS_NREQ_DEF         = 4;
   localparam int unsigned MCS_MULT_LATENCY_DEF = 2;

   // Ceiling log2, used to size requester IDs.
   function automatic int unsigned mcs_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/multiply_complex_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, searching upward mod NREQ.
module rr_arbiter
   import multiply_complex_sched_pkg::*;
#(
   parameter  int unsigned NREQ = MCS_NREQ_DEF,
   localparam int unsigned IDW  = mcs_clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id,
   output logic            any
);

   logic [IDW-1:0] idx;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      any      = 1'b0;
      idx      = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = IDW'((32'(ptr) + i) % NREQ);
         if (!any && req[idx]) begin
            any       = 1'b1;
            grant[idx] = 1'b1;
            grant_id  = idx;
         end
      end
   end

endmodule

// File: rtl/multiply_complex_sched.sv
// Shares one pipelined complex multiplier among NREQ requesters; products return
// in issue order tagged with the owning requester ID.
module multiply_complex_sched
   import multiply_complex_sched_pkg::*;
#(
   parameter  int unsigned WIDTH        = MCS_WIDTH_DEF,
   parameter  int unsigned NREQ         = MCS_NREQ_DEF,
   parameter  int unsigned MULT_LATENCY = MCS_MULT_LATENCY_DEF,
   localparam int unsigned IDW          = mcs_clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic [NREQ-1:0]       in_valid,
   input  logic [NREQ*WIDTH-1:0] in_x,
   input  logic [NREQ*WIDTH-1:0] in_y,
   output logic [NREQ-1:0]       in_ready,
   output logic [WIDTH-1:0]      mult_x,
   output logic [WIDTH-1:0]      mult_y,
   input  logic [WIDTH-1:0]      mult_z,
   output logic                  out_valid,
   output logic [IDW-1:0]        out_id,
   output logic [WIDTH-1:0]      out_data,
   output logic                  busy
);

   localparam int unsigned STAGES = MULT_LATENCY + 1;

   logic [IDW-1:0]             ptr;
   logic [IDW-1:0]             ptr_nxt;
   logic [IDW-1:0]             grant_id;
   logic [NREQ-1:0]            req;
   logic [NREQ-1:0]            grant;
   logic                       any;
   logic [STAGES-1:0]          tag_v;
   logic [STAGES-1:0]          tag_v_nxt;
   logic [STAGES-1:0][IDW-1:0] tag_id;
   logic                       out_valid_nxt;
   logic [WIDTH-1:0]           x_lane [NREQ];
   logic [WIDTH-1:0]           y_lane [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign x_lane[g] = in_x[g*WIDTH +: WIDTH];
      assign y_lane[g] = in_y[g*WIDTH +: WIDTH];
   end

   // Masking requests during clear suppresses the grant and the transfer together.
   assign req = clear ? '0 : in_valid;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req      (req),
      .ptr      (ptr),
      .grant    (grant),
      .grant_id (grant_id),
      .any      (any)
   );

   assign in_ready      = grant;
   assign ptr_nxt       = (32'(grant_id) == NREQ - 1) ? '0 : IDW'(32'(grant_id) + 32'd1);
   assign tag_v_nxt     = clear ? '0 : {tag_v[STAGES-2:0], any};
   assign out_valid_nxt = tag_v[STAGES-1] & ~clear;

   // Issue register, tag pipe aligned with the multiplier, and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         mult_x    <= '0;
         mult_y    <= '0;
         tag_v     <= '0;
         tag_id    <= '0;
         out_valid <= 1'b0;
         out_id    <= '0;
         out_data  <= '0;
         busy      <= 1'b0;
      end else begin
         if (any) begin
            ptr    <= ptr_nxt;
            mult_x <= x_lane[grant_id];
            mult_y <= y_lane[grant_id];
         end
         tag_v  <= tag_v_nxt;
         tag_id <= {tag_id[STAGES-2:0], grant_id};
         if (out_valid_nxt) begin
            out_data <= mult_z;
            out_id   <= tag_id[STAGES-1];
         end
         out_valid <= out_valid_nxt;
         busy      <= (|tag_v_nxt) | out_valid_nxt;
      end
   end

endmodule

// File: tb/tb_multiply_complex_sched.sv
// Randomized bench for multiply_complex_sched against a queue-based reference model
// and a behavioural 2-cycle complex multiplier.
module tb_multiply_complex_sched;

   localparam int unsigned WIDTH        = 32;
   localparam int unsigned NREQ         = 4;
   localparam int unsigned MULT_LATENCY = 2;
   localparam int unsigned IDW          = 2;

   typedef struct packed {
      logic [IDW-1:0]   id;
      logic [WIDTH-1:0] data;
      logic [31:0]      due;
   } exp_t;

   logic                  clk;
   logic                  rst_n;
   logic                  clear;
   logic [NREQ-1:0]       in_valid;
   logic [NREQ*WIDTH-1:0] in_x;
   logic [NREQ*WIDTH-1:0] in_y;
   logic [NREQ-1:0]       in_ready;
   logic [WIDTH-1:0]      mult_x;
   logic [WIDTH-1:0]      mult_y;
   logic [WIDTH-1:0]      mult_z;
   logic                  out_valid;
   logic [IDW-1:0]        out_id;
   logic [WIDTH-1:0]      out_data;
   logic                  busy;

   logic [WIDTH-1:0] ax [NREQ];
   logic [WIDTH-1:0] ay [NREQ];
   logic [WIDTH-1:0] mp1, mp2;

   exp_t        q[$];
   int          mptr;
   logic [31:0] edges;
   logic [WIDTH-1:0] last_data, exp_mx, exp_my;
   int          n_cmp;
   int          n_err;

   multiply_complex_sched #(
      .WIDTH(WIDTH), .NREQ(NREQ), .MULT_LATENCY(MULT_LATENCY)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_ready  (in_ready),
      .mult_x    (mult_x),
      .mult_y    (mult_y),
      .mult_z    (mult_z),
      .out_valid (out_valid),
      .out_id    (out_id),
      .out_data  (out_data),
      .busy      (busy)
   );

   for (genvar g = 0; g < NREQ; g++) begin : g_pack
      assign in_x[g*WIDTH +: WIDTH] = ax[g];
      assign in_y[g*WIDTH +: WIDTH] = ay[g];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural multiplier: Q1.15 complex product, halved, two register stages.
   function automatic logic [WIDTH-1:0] cmul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      longint xr, xi, yr, yi, pr, pi;
      xr = longint'($signed(x[31:16]));
      xi = longint'($signed(x[15:0]));
      yr = longint'($signed(y[31:16]));
      yi = longint'($signed(y[15:0]));
      pr = (xr * yr - xi * yi) >>> 16;
      pi = (xr * yi + xi * yr) >>> 16;
      return {pr[15:0], pi[15:0]};
   endfunction

   always @(posedge clk) begin
      mp1 <= cmul(mult_x, mult_y);
      mp2 <= mp1;
   end
   assign mult_z = mp2;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock of stimulus; entered and left 1 time unit after a rising edge.
   task automatic run_cycle(input logic [NREQ-1:0] v, input bit clr, input bit rnd);
      int              win;
      logic [NREQ-1:0] eg;
      bit              ev;
      exp_t            e;
      in_valid = v;
      clear    = clr;
      if (rnd) begin
         for (int i = 0; i < NREQ; i++) begin
            ax[i] = $urandom();
            ay[i] = $urandom();
         end
      end
      @(negedge clk);
      win = -1;
      if (!clr) begin
         for (int k = 0; k < NREQ; k++) begin
            if (win < 0 && v[(mptr + k) % NREQ]) win = (mptr + k) % NREQ;
         end
      end
      eg = (win >= 0) ? (NREQ'(1) << win) : '0;
      chk("in_ready", in_ready, eg);
      if (clr) q.delete();
      if (win >= 0) begin
         e.id   = IDW'(win);
         e.data = cmul(ax[win], ay[win]);
         e.due  = edges + 1 + MULT_LATENCY + 1;
         q.push_back(e);
         exp_mx = ax[win];
         exp_my = ay[win];
         mptr   = (win + 1) % NREQ;
      end
      @(posedge clk);
      #1;
      edges++;
      ev = (q.size() > 0) && (q[0].due == edges);
      chk("out_valid", out_valid, ev);
      if (ev) begin
         e = q.pop_front();
         chk("out_id", out_id, e.id);
         last_data = e.data;
      end
      chk("out_data", out_data, last_data);
      chk("mult_x", mult_x, exp_mx);
      chk("mult_y", mult_y, exp_my);
      chk("busy", busy, (q.size() > 0) || ev);
   endtask

   task automatic do_reset();
      in_valid = '0;
      clear    = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_id", out_id, 0);
      chk("rst_mult_x", mult_x, 0);
      chk("rst_mult_y", mult_y, 0);
      chk("rst_busy", busy, 0);
      q.delete();
      mptr      = 0;
      last_data = '0;
      exp_mx    = '0;
      exp_my    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      edges++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      n_cmp = 0; n_err = 0; edges = 0; mptr = 0;
      last_data = '0; exp_mx = '0; exp_my = '0;
      rst_n = 1'b0; clear = 1'b0; in_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         ax[i] = '0;
         ay[i] = '0;
      end
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_mult_x", mult_x, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      edges++;

      // Single request from requester 1.
      for (int i = 0; i < NREQ; i++) begin
         ax[i] = 32'h4000_0000;
         ay[i] = 32'h4000_0000;
      end
      run_cycle(4'b0010, 1'b0, 1'b0);
      repeat (3) run_cycle(4'b0000, 1'b0, 1'b0);
      chk("t1_valid", out_valid, 1);
      chk("t1_id", out_id, 1);
      chk("t1_data", out_data, 32'h1000_0000);
      repeat (2) run_cycle(4'b0000, 1'b0, 1'b0);

      // All requesters continuously.
      repeat (10) run_cycle(4'b1111, 1'b0, 1'b1);
      repeat (4) run_cycle(4'b0000, 1'b0, 1'b1);

      // Only requester 2.
      repeat (6) run_cycle(4'b0100, 1'b0, 1'b1);
      repeat (4) run_cycle(4'b0000, 1'b0, 1'b1);

      // Requesters 0 and 3 with the pointer moved to 1.
      run_cycle(4'b0001, 1'b0, 1'b1);
      repeat (5) run_cycle(4'b1001, 1'b0, 1'b1);
      repeat (4) run_cycle(4'b0000, 1'b0, 1'b1);

      // Clear with three results in flight.
      repeat (3) run_cycle(4'b1111, 1'b0, 1'b1);
      run_cycle(4'b1111, 1'b1, 1'b1);
      run_cycle(4'b0000, 1'b0, 1'b1);
      run_cycle(4'b0001, 1'b0, 1'b1);
      repeat (4) run_cycle(4'b0000, 1'b0, 1'b1);

      // Reset mid-stream.
      repeat (3) run_cycle(4'b1111, 1'b0, 1'b1);
      do_reset();
      run_cycle(4'b1100, 1'b0, 1'b1);
      repeat (5) run_cycle(4'b0000, 1'b0, 1'b1);

      // Random traffic with occasional clears and one reset.
      for (int c = 0; c < 300; c++) begin
         run_cycle(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0), 1'b1);
         if (c == 150) do_reset();
      end
      repeat (5) run_cycle(4'b0000, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
